// File: rtl/alu_div_seq_if.sv
// Handshake, request/result and shared-ALU signals of the divide sequencer.
// The slave modport is the sequencer side; master is the core/execute side.
interface alu_div_seq_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [1:0]      i_div_op;
  logic [XLEN-1:0] i_dividend;
  logic [XLEN-1:0] i_divisor;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic [3:0]      o_alu_op;
  logic [XLEN-1:0] o_alu_a;
  logic [XLEN-1:0] o_alu_b;
  logic [XLEN-1:0] i_alu_data;

  modport slave (
    input  i_valid, i_div_op, i_dividend, i_divisor, i_ready, i_alu_data,
    output o_ready, o_valid, o_result, o_alu_op, o_alu_a, o_alu_b
  );

  modport master (
    output i_valid, i_div_op, i_dividend, i_divisor, i_ready, i_alu_data,
    input  o_ready, o_valid, o_result, o_alu_op, o_alu_a, o_alu_b
  );
endinterface

// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle RV32M DIV/DIVU/REM/REMU sequencer driving a shared
// combinational ALU (ADD/SUB/SLTU). Restoring division on magnitudes, sign fixed
// up at the end. Fixed 67-cycle latency from accept to o_valid.
// Optional macro DIV_FASTPATH_EN: divide-by-zero and signed overflow finish
// directly with the architectural result (o_valid one edge after accept).
module alu_div_seq #(
  parameter int XLEN = 32
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_div_seq_if.slave  bus
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE, S_ABS_A, S_ABS_B, S_CMP, S_SUB, S_FIX, S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      op;
  logic            sa, sb, take;
  logic [XLEN-1:0] quo, rem, dreg, result;
  logic            valid;
  logic [4:0]      cnt;

  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_a, alu_b;
  logic [XLEN-1:0] r_shift;
  logic [XLEN-1:0] fix_x;
  logic            fix_neg;

`ifdef DIV_FASTPATH_EN
  logic            fast;
  logic [XLEN-1:0] fast_res;
  logic            div_zero;
  logic            ovf;
`endif

  // Operands are parked in quo (dividend) and dreg (divisor) until made absolute.
  assign r_shift = {rem[XLEN-2:0], quo[XLEN-1]};
  assign fix_x   = op[1] ? rem : quo;
  assign fix_neg = op[1] ? sa : ((sa ^ sb) & (dreg != '0));

`ifdef DIV_FASTPATH_EN
  // Evaluated in ABS_A, while quo/dreg still hold the raw operands.
  assign div_zero = (dreg == '0);
  assign ovf      = ~op[0] & (quo == {1'b1, {(XLEN-1){1'b0}}}) & (dreg == '1);
  assign fast     = div_zero | ovf;
  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = op[1] ? quo : '1;
    else          fast_res = op[1] ? '0  : quo;
  end
`endif

  assign bus.o_ready  = (state == S_IDLE);
  assign bus.o_valid  = valid;
  assign bus.o_result = result;
  assign bus.o_alu_op = alu_op;
  assign bus.o_alu_a  = alu_a;
  assign bus.o_alu_b  = alu_b;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state and ALU command for the current step.
  always_comb begin
    state_nxt = state;
    alu_op    = ALU_ADD;
    alu_a     = '0;
    alu_b     = '0;
    case (state)
      S_IDLE: begin
        if (bus.i_valid) state_nxt = S_ABS_A;
      end
      S_ABS_A: begin
`ifdef DIV_FASTPATH_EN
        if (fast) begin
          state_nxt = S_DONE;
        end else
`endif
        begin
          alu_op    = sa ? ALU_SUB : ALU_ADD;
          alu_a     = sa ? '0 : quo;
          alu_b     = sa ? quo : '0;
          state_nxt = S_ABS_B;
        end
      end
      S_ABS_B: begin
        alu_op    = sb ? ALU_SUB : ALU_ADD;
        alu_a     = sb ? '0 : dreg;
        alu_b     = sb ? dreg : '0;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        alu_op    = ALU_SLTU;
        alu_a     = r_shift;
        alu_b     = dreg;
        state_nxt = S_SUB;
      end
      S_SUB: begin
        alu_op    = ALU_SUB;
        alu_a     = rem;
        alu_b     = dreg;
        state_nxt = (cnt == 5'd31) ? S_FIX : S_CMP;
      end
      S_FIX: begin
        alu_op    = fix_neg ? ALU_SUB : ALU_ADD;
        alu_a     = fix_neg ? '0 : fix_x;
        alu_b     = fix_neg ? fix_x : '0;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.i_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shift/compare/subtract iterations, result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      take   <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dreg   <= '0;
      cnt    <= '0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_valid) begin
            op   <= bus.i_div_op;
            quo  <= bus.i_dividend;
            dreg <= bus.i_divisor;
            sa   <= ~bus.i_div_op[0] & bus.i_dividend[XLEN-1];
            sb   <= ~bus.i_div_op[0] & bus.i_divisor[XLEN-1];
          end
        end
        S_ABS_A: begin
`ifdef DIV_FASTPATH_EN
          if (fast) begin
            result <= fast_res;
            valid  <= 1'b1;
          end else
`endif
          begin
            quo <= bus.i_alu_data;
            rem <= '0;
            cnt <= '0;
          end
        end
        S_ABS_B: dreg <= bus.i_alu_data;
        S_CMP: begin
          rem  <= r_shift;
          quo  <= quo << 1;
          // Shifted-out MSB means the 33-bit partial remainder exceeds any divisor.
          take <= rem[XLEN-1] | ~bus.i_alu_data[0];
        end
        S_SUB: begin
          if (take) begin
            rem    <= bus.i_alu_data;
            quo[0] <= 1'b1;
          end
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          result <= bus.i_alu_data;
          valid  <= 1'b1;
        end
        S_DONE: begin
          if (bus.i_ready) valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for alu_div_seq with a behavioural ALU model.
module tb_alu_div_seq;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  alu_div_seq_if #(.XLEN(32)) bus();

  alu_div_seq #(.XLEN(32)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // Shared ALU stand-in.
  always_comb begin
    case (bus.o_alu_op)
      4'b0000: bus.i_alu_data = bus.o_alu_a + bus.o_alu_b;
      4'b1000: bus.i_alu_data = bus.o_alu_a - bus.o_alu_b;
      4'b0011: bus.i_alu_data = {31'b0, bus.o_alu_a < bus.o_alu_b};
      default: bus.i_alu_data = '0;
    endcase
  end

`ifdef DIV_FASTPATH_EN
  localparam int LAT_SPECIAL = 1;
`else
  localparam int LAT_SPECIAL = 67;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for o_valid, check latency and result; optionally release.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit release_it);
    int n;
    @(negedge i_clk);
    bus.i_valid    = 1'b1;
    bus.i_div_op   = op;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    n = 0;
    while (!bus.o_valid && n < 200) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_res"}, bus.o_result, exp);
    if (release_it) begin
      @(negedge i_clk);
      bus.i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      bus.i_ready = 1'b0;
      check({tag, "_vld_clr"}, {31'b0, bus.o_valid}, 32'd0);
      check({tag, "_rdy_back"}, {31'b0, bus.o_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] held;
    bus.i_valid    = 1'b0;
    bus.i_ready    = 1'b0;
    bus.i_div_op   = 2'b00;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;

    #12;
    check("rst_ready",  {31'b0, bus.o_ready}, 32'd1);
    check("rst_valid",  {31'b0, bus.o_valid}, 32'd0);
    check("rst_result", bus.o_result, 32'd0);
    check("rst_aluop",  {28'b0, bus.o_alu_op}, 32'd0);
    check("rst_alua",   bus.o_alu_a, 32'd0);
    check("rst_alub",   bus.o_alu_b, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 67, 1'b1);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2,  67, 1'b1);

    // First ALU step for a negative signed dividend is 0 - a.
    @(negedge i_clk);
    bus.i_valid = 1'b1; bus.i_div_op = 2'b00;
    bus.i_dividend = 32'hFFFFFFF9; bus.i_divisor = 32'd2;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    check("absa_op", {28'b0, bus.o_alu_op}, 32'h8);
    check("absa_b",  bus.o_alu_b, 32'hFFFFFFF9);
    begin
      int n;
      n = 0;
      while (!bus.o_valid && n < 200) begin
        @(posedge i_clk); #1; n++;
      end
      check("div_m7_2_lat", n, 67);
      check("div_m7_2_res", bus.o_result, 32'hFFFFFFFD);
      @(negedge i_clk); bus.i_ready = 1'b1;
      @(posedge i_clk); #1; bus.i_ready = 1'b0;
    end

    run_op("rem_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 67, 1'b1);
    run_op("div_7_m2",   2'b00, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 67, 1'b1);
    run_op("div_m5_0",   2'b00, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, LAT_SPECIAL, 1'b1);
    run_op("rem_m5_0",   2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, LAT_SPECIAL, 1'b1);
    run_op("divu_5_0",   2'b01, 32'd5,        32'd0, 32'hFFFFFFFF, LAT_SPECIAL, 1'b1);
    run_op("div_ovf",    2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPECIAL, 1'b1);
    run_op("rem_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        LAT_SPECIAL, 1'b1);
    run_op("divu_big",   2'b01, 32'hFFFFFFFF, 32'h80000001, 32'd1,        67, 1'b1);
    run_op("remu_big",   2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 67, 1'b1);

    // Back-pressure: result held, new request ignored.
    run_op("hold", 2'b01, 32'd100, 32'd7, 32'd14, 67, 1'b0);
    held = bus.o_result;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      bus.i_valid = 1'b1; bus.i_div_op = 2'b01;
      bus.i_dividend = 32'd50; bus.i_divisor = 32'd5;
      @(posedge i_clk);
      #1;
      check("hold_valid", {31'b0, bus.o_valid}, 32'd1);
      check("hold_ready", {31'b0, bus.o_ready}, 32'd0);
      check("hold_res",   bus.o_result, held);
    end
    check("hold_res_val", held, 32'd14);
    @(negedge i_clk);
    bus.i_valid = 1'b0; bus.i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    bus.i_ready = 1'b0;
    check("hold_rel_valid", {31'b0, bus.o_valid}, 32'd0);
    check("hold_rel_ready", {31'b0, bus.o_ready}, 32'd1);
    repeat (3) @(posedge i_clk);
    #1;
    check("hold_no_queue", {31'b0, bus.o_ready}, 32'd1);

    // Reset during an operation.
    @(negedge i_clk);
    bus.i_valid = 1'b1; bus.i_div_op = 2'b00;
    bus.i_dividend = 32'd1000; bus.i_divisor = 32'd3;
    @(posedge i_clk);
    #1;
    bus.i_valid = 1'b0;
    repeat (30) @(posedge i_clk);
    #1;
    check("mid_busy", {31'b0, bus.o_ready}, 32'd0);
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'b0, bus.o_ready}, 32'd1);
    check("mid_rst_valid", {31'b0, bus.o_valid}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 67, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
